// File: rtl/gnss_corr_pkg.sv
// Shared constants and helpers for the EPL correlator.
// Replica polarity and saturating arithmetic live here.
package gnss_corr_pkg;

    localparam int SAMP_W_DEF = 3;
    localparam int ACC_W_DEF  = 16;

    // Replica bit meaning: 0 is +1, 1 is -1.
    localparam logic REP_POS = 1'b0;
    localparam logic REP_NEG = 1'b1;

    // Signed add clamped to a w-bit range (w <= 32).
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = {a[31], a} + {b[31], b};
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi[31:0];
        end else if (s < lo) begin
            return lo[31:0];
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/epl_correlator_if.sv
// Dump bus from the correlator to the loop processor.
// Six signed sums qualified by a valid/ready pair.
interface epl_correlator_if
    import gnss_corr_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic                    dump_valid;
    logic                    dump_ready;
    logic signed [ACC_W-1:0] ie;
    logic signed [ACC_W-1:0] qe;
    logic signed [ACC_W-1:0] ip;
    logic signed [ACC_W-1:0] qp;
    logic signed [ACC_W-1:0] il;
    logic signed [ACC_W-1:0] ql;

    modport master (
        output dump_valid,
        output ie, qe, ip, qp, il, ql,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  ie, qe, ip, qp, il, ql,
        output dump_ready
    );
endinterface

// File: rtl/corr_arm.sv
// One despreading arm: negate-on-replica plus a
// saturating accumulator that restarts after each epoch.
module corr_arm
    import gnss_corr_pkg::*;
#(
    parameter int SAMP_W = SAMP_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     samp_valid,
    input  logic                     epoch,
    input  logic                     rep,
    input  logic signed [SAMP_W-1:0] samp,
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [SAMP_W:0]   w_samp_x;
    logic signed [SAMP_W:0]   w_term;
    logic signed [31:0]       w_sum32;

    // Widen by one bit first so negating the most
    // negative sample cannot wrap.
    assign w_samp_x = {samp[SAMP_W-1], samp};
    assign w_term   = (rep == REP_NEG) ? -w_samp_x
                                       : w_samp_x;
    assign w_sum32  = sat_add(32'(r_acc),
                              32'(w_term), ACC_W);
    assign sum      = ACC_W'(w_sum32);

    // Integrate; clear on disable and after an epoch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (!en) begin
            r_acc <= '0;
        end else if (samp_valid) begin
            r_acc <= epoch ? '0 : sum;
        end
    end

endmodule

// File: rtl/epl_correlator.sv
// Early/prompt/late correlator: replica delay line,
// six arms, and the dump handshake with overrun tracking.
module epl_correlator
    import gnss_corr_pkg::*;
#(
    parameter int SAMP_W = SAMP_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     samp_valid,
    input  logic signed [SAMP_W-1:0] samp_i,
    input  logic signed [SAMP_W-1:0] samp_q,
    input  logic                     chip,
    input  logic                     half_tick,
    input  logic                     epoch,
    output logic                     overrun,
    input  logic                     overrun_clr,
    epl_correlator_if.master         dmp
);

    logic [1:0]              r_d;
    logic                    r_dv;
    logic                    r_ovr;
    logic signed [ACC_W-1:0] r_dump [6];
    logic signed [ACC_W-1:0] w_cand [6];
    logic                    w_rep  [3];
    logic                    w_take;
    logic                    w_xfer;
    logic                    w_load;
    logic                    w_lost;

    // Early is the live chip; prompt/late see the
    // pre-update delay line.
    assign w_rep[0] = chip;
    assign w_rep[1] = r_d[0];
    assign w_rep[2] = r_d[1];

    for (genvar g = 0; g < 6; g++) begin : g_arm
        corr_arm #(
            .SAMP_W (SAMP_W),
            .ACC_W  (ACC_W)
        ) u_arm (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .samp_valid (samp_valid),
            .epoch      (epoch),
            .rep        (w_rep[g/2]),
            .samp       ((g % 2 == 0) ? samp_i : samp_q),
            .sum        (w_cand[g])
        );
    end

    assign w_take = samp_valid & en & epoch;
    assign w_xfer = r_dv & dmp.dump_ready;
    assign w_load = w_take & (~r_dv | w_xfer);
    assign w_lost = w_take & r_dv & ~w_xfer;

    // Half-chip delay line for prompt and late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= '0;
        end else if (samp_valid & half_tick & en) begin
            r_d <= {r_d[0], chip};
        end
    end

    // Dump valid: set on load, drop on a bare transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv <= 1'b0;
        end else if (w_load) begin
            r_dv <= 1'b1;
        end else if (w_xfer) begin
            r_dv <= 1'b0;
        end
    end

    // Dump registers capture the candidate sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) begin
                r_dump[k] <= '0;
            end
        end else if (w_load) begin
            for (int k = 0; k < 6; k++) begin
                r_dump[k] <= w_cand[k];
            end
        end
    end

    // Sticky overrun; a new loss beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (w_lost) begin
            r_ovr <= 1'b1;
        end else if (overrun_clr) begin
            r_ovr <= 1'b0;
        end
    end

    assign dmp.dump_valid = r_dv;
    assign dmp.ie         = r_dump[0];
    assign dmp.qe         = r_dump[1];
    assign dmp.ip         = r_dump[2];
    assign dmp.qp         = r_dump[3];
    assign dmp.il         = r_dump[4];
    assign dmp.ql         = r_dump[5];
    assign overrun        = r_ovr;

endmodule

// File: tb/tb_epl_correlator.sv
// Scoreboard bench for epl_correlator: expected dumps
// are queued at stimulus time and popped on each transfer.
module tb_epl_correlator;

    typedef struct {
        string nm;
        int    v [6];
    } exp_t;

    logic clk;
    logic rst_n;

    logic             en, sv, chip, ht, ep, oclr;
    logic signed [2:0] si, sq;
    logic             ovr;

    logic             sv8, chip8, ht8, ep8;
    logic signed [2:0] si8, sq8;
    logic             ovr8;

    int errors = 0;
    int checks = 0;

    exp_t q16[$];
    exp_t q8[$];
    exp_t m16_e;
    exp_t m8_e;
    int   m16_a [6];
    int   m8_a  [6];

    epl_correlator_if #(.ACC_W(16)) bus16 ();
    epl_correlator_if #(.ACC_W(8))  bus8 ();

    epl_correlator #(.SAMP_W(3), .ACC_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .samp_valid  (sv),
        .samp_i      (si),
        .samp_q      (sq),
        .chip        (chip),
        .half_tick   (ht),
        .epoch       (ep),
        .overrun     (ovr),
        .overrun_clr (oclr),
        .dmp         (bus16)
    );

    epl_correlator #(.SAMP_W(3), .ACC_W(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (1'b1),
        .samp_valid  (sv8),
        .samp_i      (si8),
        .samp_q      (sq8),
        .chip        (chip8),
        .half_tick   (ht8),
        .epoch       (ep8),
        .overrun     (ovr8),
        .overrun_clr (1'b0),
        .dmp         (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string n,
        input int a, input int b, input int c,
        input int d, input int e, input int f);
        exp_t x;
        x.nm = n;
        x.v[0] = a; x.v[1] = b; x.v[2] = c;
        x.v[3] = d; x.v[4] = e; x.v[5] = f;
        return x;
    endfunction

    task automatic chk(input string n, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     n, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic c, input logic h,
                       input logic e, input int i,
                       input int q);
        chip = c; ht = h; ep = e;
        si = i[2:0]; sq = q[2:0]; sv = 1'b1;
        @(posedge clk);
        #1;
        sv = 1'b0; ht = 1'b0; ep = 1'b0;
    endtask

    task automatic smp8(input logic c, input logic h,
                        input logic e, input int i);
        chip8 = c; ht8 = h; ep8 = e;
        si8 = i[2:0]; sq8 = 3'sd0; sv8 = 1'b1;
        @(posedge clk);
        #1;
        sv8 = 1'b0; ht8 = 1'b0; ep8 = 1'b0;
    endtask

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (rst_n && bus16.dump_valid &&
            bus16.dump_ready) begin
            checks++;
            m16_a[0] = int'(bus16.ie);
            m16_a[1] = int'(bus16.qe);
            m16_a[2] = int'(bus16.ip);
            m16_a[3] = int'(bus16.qp);
            m16_a[4] = int'(bus16.il);
            m16_a[5] = int'(bus16.ql);
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL dump16 unexpected: ie=%0d",
                         m16_a[0]);
            end else begin
                m16_e = q16.pop_front();
                if (m16_a != m16_e.v) begin
                    errors++;
                    $display({"FAIL %s: got %0d %0d %0d",
                        " %0d %0d %0d expected %0d %0d",
                        " %0d %0d %0d %0d"}, m16_e.nm,
                        m16_a[0], m16_a[1], m16_a[2],
                        m16_a[3], m16_a[4], m16_a[5],
                        m16_e.v[0], m16_e.v[1],
                        m16_e.v[2], m16_e.v[3],
                        m16_e.v[4], m16_e.v[5]);
                end
            end
        end
    end

    // Monitor for the 8-bit saturation instance.
    always @(negedge clk) begin
        if (rst_n && bus8.dump_valid &&
            bus8.dump_ready) begin
            checks++;
            m8_a[0] = int'(bus8.ie);
            m8_a[1] = int'(bus8.qe);
            m8_a[2] = int'(bus8.ip);
            m8_a[3] = int'(bus8.qp);
            m8_a[4] = int'(bus8.il);
            m8_a[5] = int'(bus8.ql);
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL dump8 unexpected: ie=%0d",
                         m8_a[0]);
            end else begin
                m8_e = q8.pop_front();
                if (m8_a != m8_e.v) begin
                    errors++;
                    $display({"FAIL %s: got %0d %0d %0d",
                        " %0d %0d %0d expected %0d %0d",
                        " %0d %0d %0d %0d"}, m8_e.nm,
                        m8_a[0], m8_a[1], m8_a[2],
                        m8_a[3], m8_a[4], m8_a[5],
                        m8_e.v[0], m8_e.v[1],
                        m8_e.v[2], m8_e.v[3],
                        m8_e.v[4], m8_e.v[5]);
                end
            end
        end
    end

    initial begin
        logic [7:0] hc;
        hc = 8'b0110_0110;
        rst_n = 1'b0;
        en = 1'b0; sv = 1'b0; chip = 1'b0; ht = 1'b0;
        ep = 1'b0; oclr = 1'b0; si = '0; sq = '0;
        sv8 = 1'b0; chip8 = 1'b0; ht8 = 1'b0;
        ep8 = 1'b0; si8 = '0; sq8 = '0;
        bus16.dump_ready = 1'b0;
        bus8.dump_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dump_valid", int'(bus16.dump_valid), 0);
        chk("reset overrun", int'(ovr), 0);
        chk("reset ie", int'(bus16.ie), 0);
        rst_n = 1'b1;
        idle(1);

        // Steady input over one full epoch.
        en = 1'b1;
        bus16.dump_ready = 1'b1;
        q16.push_back(mk("steady", 1023, -2046, 1023,
                         -2046, 1023, -2046));
        for (int k = 0; k < 1023; k++)
            smp(1'b0, 1'b0, k == 1022, 1, -2);
        chk("steady dump_valid", int'(bus16.dump_valid), 1);
        idle(1);

        // Half-chip offsets; d ends at 2'b10.
        q16.push_back(mk("halfchip", 0, 0, 0, 0, 2, -2));
        for (int k = 0; k < 8; k++)
            smp(hc[k], 1'b1, k == 7, 1, -1);
        idle(1);

        // Overrun: hold ready low across two epochs.
        bus16.dump_ready = 1'b0;
        q16.push_back(mk("ovr_first", 6, 3, 6, 3, -6, -3));
        smp(1'b0, 1'b0, 1'b0, 2, 1);
        smp(1'b0, 1'b0, 1'b0, 2, 1);
        smp(1'b0, 1'b0, 1'b1, 2, 1);
        chk("first dump_valid", int'(bus16.dump_valid), 1);
        chk("no overrun yet", int'(ovr), 0);
        smp(1'b0, 1'b0, 1'b0, 1, 1);
        smp(1'b0, 1'b0, 1'b1, 1, 1);
        chk("overrun set", int'(ovr), 1);
        chk("held ie", int'(bus16.ie), 6);
        chk("held ql", int'(bus16.ql), -3);
        oclr = 1'b1;
        idle(1);
        oclr = 1'b0;
        chk("overrun cleared", int'(ovr), 0);
        q16.push_back(mk("ovr_coinc", -2, 4, -2, 4, 2, -4));
        smp(1'b0, 1'b0, 1'b0, -1, 2);
        bus16.dump_ready = 1'b1;
        smp(1'b0, 1'b0, 1'b1, -1, 2);
        chk("coinc dump_valid", int'(bus16.dump_valid), 1);
        chk("coinc overrun", int'(ovr), 0);
        chk("coinc ie", int'(bus16.ie), -2);
        idle(1);
        bus16.dump_ready = 1'b0;
        chk("drained dump_valid", int'(bus16.dump_valid), 0);

        // Set and clear together: set wins.
        q16.push_back(mk("pending", 1, 0, 1, 0, -1, 0));
        smp(1'b0, 1'b0, 1'b1, 1, 0);
        oclr = 1'b1;
        smp(1'b0, 1'b0, 1'b1, 1, 0);
        oclr = 1'b0;
        chk("set beats clear", int'(ovr), 1);
        chk("pending ie", int'(bus16.ie), 1);
        oclr = 1'b1;
        idle(1);
        oclr = 1'b0;

        // Disable mid-epoch; pending dump drains.
        smp(1'b0, 1'b0, 1'b0, 3, 0);
        smp(1'b0, 1'b0, 1'b0, 3, 0);
        en = 1'b0;
        bus16.dump_ready = 1'b1;
        smp(1'b1, 1'b1, 1'b1, 1, 1);
        bus16.dump_ready = 1'b0;
        smp(1'b1, 1'b1, 1'b1, 1, 1);
        chk("disabled no epoch", int'(bus16.dump_valid), 0);
        en = 1'b1;
        bus16.dump_ready = 1'b1;
        q16.push_back(mk("reenable", 2, 2, 2, 2, -2, -2));
        smp(1'b0, 1'b0, 1'b0, 1, 1);
        smp(1'b0, 1'b0, 1'b1, 1, 1);
        idle(1);
        bus16.dump_ready = 1'b0;

        // Asynchronous reset mid-integration.
        smp(1'b0, 1'b0, 1'b0, 1, 0);
        smp(1'b0, 1'b0, 1'b1, 1, 0);
        smp(1'b0, 1'b0, 1'b1, 1, 0);
        chk("pre-reset overrun", int'(ovr), 1);
        for (int k = 0; k < 3; k++)
            smp(1'b0, 1'b0, 1'b0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async dump_valid", int'(bus16.dump_valid), 0);
        chk("async overrun", int'(ovr), 0);
        chk("async ie", int'(bus16.ie), 0);
        chk("async qe", int'(bus16.qe), 0);
        chk("async ip", int'(bus16.ip), 0);
        chk("async qp", int'(bus16.qp), 0);
        chk("async il", int'(bus16.il), 0);
        chk("async ql", int'(bus16.ql), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus16.dump_ready = 1'b1;
        q16.push_back(mk("post_reset", 3, -3, 3, -3, 3, -3));
        smp(1'b0, 1'b0, 1'b0, 1, -1);
        smp(1'b0, 1'b0, 1'b0, 1, -1);
        smp(1'b0, 1'b0, 1'b1, 1, -1);
        idle(1);

        // Saturation on the 8-bit instance.
        q8.push_back(mk("sat_pos", 127, 0, 127, 0, 127, 0));
        for (int k = 0; k < 100; k++)
            smp8(1'b0, 1'b1, k == 99, 3);
        q8.push_back(mk("sat_negneg", 127, 0, 127, 0,
                        127, 0));
        for (int k = 0; k < 100; k++)
            smp8(1'b1, 1'b1, k == 99, -4);
        q8.push_back(mk("sat_neg", -128, 0, -128, 0,
                        -128, 0));
        for (int k = 0; k < 100; k++)
            smp8(1'b1, 1'b1, k == 99, 3);

        for (int k = 0; k < 50; k++) begin
            if (q16.size() == 0 && q8.size() == 0) break;
            idle(1);
        end
        checks++;
        if (q16.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL drain: left %0d and %0d expected 0",
                     q16.size(), q8.size());
        end
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
